// File: rtl/tx_pkt_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tx_pkt_sched
//  Purpose  : Transmit packet scheduler. Arbitrates video lines against
//             buffered audio units, launches one packet at a time, tracks
//             the transmitter with a watchdog, and inserts an idle gap after
//             each packet.
//  Options  : TX_SCHED_VIDAX_EN - when defined, a video grant made during
//             vertical blanking with audio pending is sent as video+audio
//             (type 10) carrying one audio unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_pkt_sched #(
  parameter int AUDIOMAX   = 20,
  parameter int AUD_THRESH = 8,
  parameter int AUD_TMO    = 2000,
  parameter int VID_RUN    = 2,
  parameter int WDOG       = 4095,
  parameter int GAP_CYC    = 4
) (
  input  logic       tx_clk,
  input  logic       sys_rst,
  input  logic       vid_rdy,
  input  logic       vperi,
  input  logic [4:0] aud_cnt,
  input  logic       tx_done,
  output logic       pkt_start,
  output logic [1:0] pkt_type,
  output logic [4:0] pkt_ade,
  output logic       busy,
  output logic       wdog_err
);

  // Counter widths sized from the parameters (never below one bit).
  localparam int c_WDW = (WDOG > 1)    ? $clog2(WDOG + 1)    : 1;
  localparam int c_GW  = (GAP_CYC > 1) ? $clog2(GAP_CYC)     : 1;
  localparam int c_SW  = (VID_RUN > 0) ? $clog2(VID_RUN + 1) : 1;

  localparam logic [c_WDW-1:0] c_WDOG       = c_WDW'(WDOG);
  localparam logic [c_GW-1:0]  c_GAP_LAST   = c_GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [c_SW-1:0]  c_VID_RUN    = c_SW'(VID_RUN);
  localparam logic [5:0]       c_AUD_THRESH = 6'(AUD_THRESH);
  localparam logic [4:0]       c_AUDIOMAX   = 5'(AUDIOMAX);
  localparam logic [15:0]      c_AUD_TMO    = 16'(AUD_TMO);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  localparam logic [1:0] c_T_VID = 2'b00;
  localparam logic [1:0] c_T_AUD = 2'b01;
  localparam logic [1:0] c_T_VAX = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       r_type;
  logic [4:0]       r_ade;
  logic             r_err;
  logic [c_WDW-1:0] r_wdog;
  logic [c_GW-1:0]  r_gap;
  logic [15:0]      r_age;
  logic [c_SW-1:0]  r_streak;

  logic       w_idle;
  logic       w_aud_pend;
  logic       w_aud_urgent;
  logic       w_grant_aud;
  logic       w_grant_vid;
  logic       w_vidax;
  logic       w_carries_aud;
  logic       w_wdog_exp;
  logic [4:0] w_ade_aud;

  assign w_idle       = (r_state == c_IDLE);
  assign w_aud_pend   = (aud_cnt != 5'd0);
  assign w_aud_urgent = ({1'b0, aud_cnt} >= c_AUD_THRESH) ||
                        (r_age >= c_AUD_TMO) ||
                        (w_aud_pend && (r_streak >= c_VID_RUN));

  // Audio outranks video when urgent; otherwise video first, then leftover audio.
  assign w_grant_aud = w_idle && (w_aud_urgent || (!vid_rdy && w_aud_pend));
  assign w_grant_vid = w_idle && !w_aud_urgent && vid_rdy;
  assign w_ade_aud   = (aud_cnt > c_AUDIOMAX) ? c_AUDIOMAX : aud_cnt;
  assign w_wdog_exp  = (r_wdog <= c_WDW'(1));

`ifdef TX_SCHED_VIDAX_EN
  assign w_vidax = w_grant_vid && vperi && w_aud_pend;
`else
  // Blanking indication has no effect without the video+audio packet type.
  logic w_unused_vperi;
  assign w_unused_vperi = vperi;
  assign w_vidax        = 1'b0;
`endif

  assign w_carries_aud = w_grant_aud || w_vidax;

  // Packet sequencing, grant capture, watchdog and gap timing.
  always_ff @(posedge tx_clk) begin
    if (sys_rst) begin
      r_state <= c_IDLE;
      r_type  <= c_T_VID;
      r_ade   <= 5'd0;
      r_err   <= 1'b0;
      r_wdog  <= '0;
      r_gap   <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant_aud) begin
            r_state <= c_ISSUE;
            r_type  <= c_T_AUD;
            r_ade   <= w_ade_aud;
          end else if (w_vidax) begin
            r_state <= c_ISSUE;
            r_type  <= c_T_VAX;
            r_ade   <= 5'd1;
          end else if (w_grant_vid) begin
            r_state <= c_ISSUE;
            r_type  <= c_T_VID;
            r_ade   <= 5'd0;
          end
        end
        c_ISSUE: begin
          r_state <= c_WAIT;
          r_wdog  <= c_WDOG;
        end
        c_WAIT: begin
          // A done pulse on the expiry cycle still counts as a clean finish.
          if (tx_done) begin
            r_state <= c_GAP;
            r_gap   <= c_GAP_LAST;
          end else if (w_wdog_exp) begin
            r_state <= c_GAP;
            r_gap   <= c_GAP_LAST;
            r_err   <= 1'b1;
            r_wdog  <= '0;
          end else begin
            r_wdog  <= r_wdog - c_WDW'(1);
          end
        end
        c_GAP: begin
          if (r_gap == '0) begin
            r_state <= c_IDLE;
          end else begin
            r_gap   <= r_gap - c_GW'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Age of the oldest buffered audio; frozen while a packet is on the wire.
  always_ff @(posedge tx_clk) begin
    if (sys_rst) begin
      r_age <= 16'd0;
    end else if (!w_aud_pend || w_carries_aud) begin
      r_age <= 16'd0;
    end else if ((r_state != c_WAIT) && (r_age != 16'hFFFF)) begin
      r_age <= r_age + 16'd1;
    end
  end

  // Run length of video grants since audio last went out.
  always_ff @(posedge tx_clk) begin
    if (sys_rst) begin
      r_streak <= '0;
    end else if (w_carries_aud) begin
      r_streak <= '0;
    end else if (w_grant_vid && (r_streak < c_VID_RUN)) begin
      r_streak <= r_streak + c_SW'(1);
    end
  end

  assign pkt_start = (r_state == c_ISSUE);
  assign busy      = !w_idle;
  assign pkt_type  = r_type;
  assign pkt_ade   = r_ade;
  assign wdog_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tx_pkt_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_tx_pkt_sched
//  Purpose  : Self-checking bench for tx_pkt_sched against a timestamp-based
//             packet model. Honours TX_SCHED_VIDAX_EN the same way as the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_pkt_sched;

  localparam int AUDIOMAX   = 20;
  localparam int AUD_THRESH = 8;
  localparam int AUD_TMO    = 2000;
  localparam int VID_RUN    = 2;
  localparam int WDOG       = 4095;
  localparam int GAP_CYC    = 4;
`ifdef TX_SCHED_VIDAX_EN
  localparam bit VIDAX = 1'b1;
`else
  localparam bit VIDAX = 1'b0;
`endif

  logic       tx_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       vid_rdy = 1'b0;
  logic       vperi = 1'b0;
  logic [4:0] aud_cnt = 5'd0;
  logic       tx_done = 1'b0;
  logic       pkt_start;
  logic [1:0] pkt_type;
  logic [4:0] pkt_ade;
  logic       busy;
  logic       wdog_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 tx_clk = ~tx_clk;

  tx_pkt_sched #(
    .AUDIOMAX  (AUDIOMAX),
    .AUD_THRESH(AUD_THRESH),
    .AUD_TMO   (AUD_TMO),
    .VID_RUN   (VID_RUN),
    .WDOG      (WDOG),
    .GAP_CYC   (GAP_CYC)
  ) u_dut (
    .tx_clk   (tx_clk),
    .sys_rst  (sys_rst),
    .vid_rdy  (vid_rdy),
    .vperi    (vperi),
    .aud_cnt  (aud_cnt),
    .tx_done  (tx_done),
    .pkt_start(pkt_start),
    .pkt_type (pkt_type),
    .pkt_ade  (pkt_ade),
    .busy     (busy),
    .wdog_err (wdog_err)
  );

  logic [9:0] w_obs;
  assign w_obs = {pkt_start, busy, wdog_err, pkt_type, pkt_ade};

  // Reference model: each packet is a set of timestamps (start, end of wait);
  // outputs for the next cycle follow from where the current cycle sits.
  int         m_cyc = 0;
  bit         m_act = 0;
  int         m_tstart = -10;
  int         m_tend = -1;
  int         m_age = 0;
  int         m_streak = 0;
  bit         m_err = 0;
  logic [1:0] m_type = 2'b00;
  logic [4:0] m_ade = 5'd0;
  logic [9:0] m_exp = 10'd0;

  always @(posedge tx_clk) begin : p_model
    bit waiting, urgent, g_aud, g_vid, g_vax;
    int a;
    if (sys_rst) begin
      m_act = 0; m_tstart = -10; m_tend = -1; m_age = 0; m_streak = 0;
      m_err = 0; m_type = 2'b00; m_ade = 5'd0;
    end else begin
      a = int'(aud_cnt);
      waiting = m_act && (m_cyc > m_tstart) && (m_tend < 0);
      urgent  = (a >= AUD_THRESH) || (m_age >= AUD_TMO) || (a != 0 && m_streak >= VID_RUN);
      g_aud = 0; g_vid = 0; g_vax = 0;
      if (!m_act) begin
        if (urgent)       g_aud = 1;
        else if (vid_rdy) g_vid = 1;
        else if (a != 0)  g_aud = 1;
        g_vax = g_vid && VIDAX && vperi && (a != 0);
        if (g_aud || g_vid) begin
          m_act = 1; m_tstart = m_cyc + 1; m_tend = -1;
          if (g_aud)      begin m_type = 2'b01; m_ade = 5'((a > AUDIOMAX) ? AUDIOMAX : a); end
          else if (g_vax) begin m_type = 2'b10; m_ade = 5'd1; end
          else            begin m_type = 2'b00; m_ade = 5'd0; end
        end
      end else if (m_cyc > m_tstart) begin
        if (m_tend < 0) begin
          if (tx_done) m_tend = m_cyc;
          else if (m_cyc - m_tstart >= WDOG) begin m_tend = m_cyc; m_err = 1; end
        end else if (m_cyc >= m_tend + GAP_CYC) begin
          m_act = 0;
        end
      end
      if (a == 0 || g_aud || g_vax)      m_age = 0;
      else if (!waiting && m_age < 65535) m_age = m_age + 1;
      if (g_aud || g_vax)                    m_streak = 0;
      else if (g_vid && m_streak < VID_RUN)  m_streak = m_streak + 1;
    end
    m_exp = {(m_act && m_tstart == m_cyc + 1), m_act, m_err, m_type, m_ade};
    m_cyc = m_cyc + 1;
  end

  task automatic do_reset();
    sys_rst = 1'b1; tx_done = 1'b0;
    @(negedge tx_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; vid_rdy = 1'b1; aud_cnt = 5'd9; tx_done = 1'b0;
    repeat (3) @(negedge tx_clk);
    n_checks++;
    if (w_obs !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", w_obs, 10'd0);
    end
    vid_rdy = 1'b0; aud_cnt = 5'd0;
    sys_rst = 1'b0;
  endtask

  // Video only, done 100 cycles after each start; start-to-start spacing fixed.
  task automatic test_video_stream();
    int since = 1000;
    int last = -1;
    do_reset();
    vid_rdy = 1'b1; aud_cnt = 5'd0; vperi = 1'b0;
    for (int c = 0; c < 450; c++) begin
      @(negedge tx_clk);
      n_checks++;
      if (w_obs !== m_exp) begin
        n_errors++;
        $display("FAIL video_stream: cycle %0d got %h expected %h", c, w_obs, m_exp);
      end
      if (pkt_start) begin
        if (last >= 0) begin
          n_checks++;
          if (c - last !== 100 + GAP_CYC + 2) begin
            n_errors++;
            $display("FAIL video_spacing: got %0d expected %0d", c - last, 100 + GAP_CYC + 2);
          end
        end
        last = c; since = 0;
      end else begin
        since++;
      end
      tx_done = (since == 100);
    end
    vid_rdy = 1'b0; tx_done = 1'b0;
  endtask

  // Video vs pending audio: two video grants then audio; large backlog capped.
  task automatic test_audio_mix();
    int since = 1000;
    int n = 0;
    logic [6:0] exp_pkt;
    do_reset();
    vid_rdy = 1'b1; aud_cnt = 5'd3; vperi = 1'b0;
    for (int c = 0; c < 300 && n < 6; c++) begin
      @(negedge tx_clk);
      n_checks++;
      if (w_obs !== m_exp) begin
        n_errors++;
        $display("FAIL audio_mix: cycle %0d got %h expected %h", c, w_obs, m_exp);
      end
      if (pkt_start) begin
        exp_pkt = (n % 3 == 2) ? {2'b01, 5'd3} : {2'b00, 5'd0};
        n_checks++;
        if ({pkt_type, pkt_ade} !== exp_pkt) begin
          n_errors++;
          $display("FAIL mix_grant%0d: got %h expected %h", n, {pkt_type, pkt_ade}, exp_pkt);
        end
        n++; since = 0;
      end else begin
        since++;
      end
      tx_done = (since == 5);
    end
    n_checks++;
    if (n < 6) begin
      n_errors++;
      $display("FAIL mix_timeout: got %0d packets expected 6", n);
    end
    do_reset();
    aud_cnt = 5'd25; n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(negedge tx_clk);
      if (pkt_start) begin
        n++;
        n_checks++;
        if ({pkt_type, pkt_ade} !== {2'b01, 5'd20}) begin
          n_errors++;
          $display("FAIL audio_cap: got %h expected %h", {pkt_type, pkt_ade}, {2'b01, 5'd20});
        end
      end
    end
    n_checks++;
    if (n == 0) begin
      n_errors++;
      $display("FAIL cap_timeout: got 0 packets expected 1");
    end
    vid_rdy = 1'b0; aud_cnt = 5'd0; tx_done = 1'b0;
  endtask

  // No done pulse: error exactly WDOG cycles after wait entry, sticky after.
  task automatic test_watchdog();
    int k = -1;
    int s = -1;
    do_reset();
    vid_rdy = 1'b1; aud_cnt = 5'd0;
    for (int c = 0; c < WDOG + 60 && k < 0; c++) begin
      @(negedge tx_clk);
      n_checks++;
      if (w_obs !== m_exp) begin
        n_errors++;
        $display("FAIL watchdog: cycle %0d got %h expected %h", c, w_obs, m_exp);
      end
      if (pkt_start) begin s = c; vid_rdy = 1'b0; end
      if (wdog_err && k < 0) k = c;
    end
    n_checks++;
    if (s < 0 || k < 0 || (k - s) !== WDOG + 1) begin
      n_errors++;
      $display("FAIL wdog_timing: got %0d expected %0d", k - s, WDOG + 1);
    end
    for (int j = 1; j <= GAP_CYC + 2; j++) begin
      @(negedge tx_clk);
      n_checks++;
      if (w_obs !== m_exp) begin
        n_errors++;
        $display("FAIL wdog_gap: step %0d got %h expected %h", j, w_obs, m_exp);
      end
      if (j == GAP_CYC) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_errors++;
          $display("FAIL wdog_idle: got busy=%b expected 0", busy);
        end
      end
    end
    vid_rdy = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge tx_clk);
      tx_done = pkt_start;
      if (pkt_start) vid_rdy = 1'b0;
    end
    tx_done = 1'b0;
    n_checks++;
    if (wdog_err !== 1'b1 || w_obs !== m_exp) begin
      n_errors++;
      $display("FAIL wdog_sticky: got %h expected %h", w_obs, m_exp);
    end
  endtask

  // Done pulse on the final allowed cycle is a clean completion.
  task automatic test_done_at_expiry();
    int since = -1;
    do_reset();
    vid_rdy = 1'b1; aud_cnt = 5'd0;
    for (int c = 0; c < WDOG + 20; c++) begin
      @(negedge tx_clk);
      n_checks++;
      if (w_obs !== m_exp) begin
        n_errors++;
        $display("FAIL done_expiry: cycle %0d got %h expected %h", c, w_obs, m_exp);
      end
      if (pkt_start) begin since = 0; vid_rdy = 1'b0; end
      else if (since >= 0) since++;
      tx_done = (since == WDOG);
    end
    n_checks++;
    if (wdog_err !== 1'b0) begin
      n_errors++;
      $display("FAIL expiry_race: got wdog_err=%b expected 0", wdog_err);
    end
  endtask

  // Reset held three cycles while waiting for the transmitter.
  task automatic test_reset_mid();
    do_reset();
    vid_rdy = 1'b1;
    for (int c = 0; c < 10 && !pkt_start; c++) @(negedge tx_clk);
    vid_rdy = 1'b0;
    repeat (5) @(negedge tx_clk);
    sys_rst = 1'b1;
    @(negedge tx_clk);
    n_checks++;
    if (w_obs !== 10'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got %h expected %h", w_obs, 10'd0);
    end
    repeat (2) @(negedge tx_clk);
    sys_rst = 1'b0; aud_cnt = 5'd0; tx_done = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge tx_clk);
      n_checks++;
      if (pkt_start !== 1'b0 || w_obs !== m_exp) begin
        n_errors++;
        $display("FAIL reset_release: got %h expected %h", w_obs, m_exp);
      end
    end
  endtask

  // Blanking with audio pending: type depends on the build option.
  task automatic test_vidax();
    logic [6:0] exp_pkt;
    bit seen = 0;
    exp_pkt = VIDAX ? {2'b10, 5'd1} : {2'b00, 5'd0};
    do_reset();
    vperi = 1'b1; vid_rdy = 1'b1; aud_cnt = 5'd2;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge tx_clk);
      if (pkt_start) begin
        seen = 1;
        n_checks++;
        if ({pkt_type, pkt_ade} !== exp_pkt) begin
          n_errors++;
          $display("FAIL vidax: got %h expected %h", {pkt_type, pkt_ade}, exp_pkt);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL vidax_timeout: got no start expected one");
    end
    vperi = 1'b0; vid_rdy = 1'b0; aud_cnt = 5'd0;
  endtask

  // Randomised traffic including stray done pulses and occasional resets.
  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge tx_clk);
      n_checks++;
      if (w_obs !== m_exp) begin
        n_errors++;
        $display("FAIL random: cycle %0d got %h expected %h", c, w_obs, m_exp);
      end
      r = int'($urandom_range(0, 7));
      if (r <= 2)      aud_cnt = 5'd0;
      else if (r <= 5) aud_cnt = 5'($urandom_range(1, 7));
      else if (r == 6) aud_cnt = 5'($urandom_range(8, 31));
      else             aud_cnt = 5'($urandom_range(0, 31));
      vid_rdy = ($urandom_range(0, 2) != 0);
      vperi   = ($urandom_range(0, 1) != 0);
      tx_done = ($urandom_range(0, 5) == 0);
      sys_rst = ($urandom_range(0, 499) == 0);
    end
    sys_rst = 1'b0; tx_done = 1'b0; vid_rdy = 1'b0; aud_cnt = 5'd0; vperi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_video_stream();
    test_audio_mix();
    test_watchdog();
    test_done_at_expiry();
    test_reset_mid();
    test_vidax();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
